// File: rtl/inst_seq_if.sv
// Control bus between the instruction sequencer, its instruction ROM and the
// ALU/register-file datapath.
interface inst_seq_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              pause;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic [15:0]       regEnable;
  logic              flagEn;
  logic              RorI;
  logic [7:0]        opcode;
  logic [3:0]        Rsrc;
  logic [3:0]        Rdest;
  logic [15:0]       imm;
  logic              busy;
  logic              halted;
  logic              illegal;

  // The sequencer side: drives the ROM port and the datapath control bundle.
  modport master (
    input  start, pause, imem_rdata,
    output imem_en, imem_addr, regEnable, flagEn, RorI, opcode, Rsrc, Rdest,
           imm, busy, halted, illegal
  );

  // The environment side: ROM, datapath and whoever starts/pauses the program.
  modport slave (
    output start, pause, imem_rdata,
    input  imem_en, imem_addr, regEnable, flagEn, RorI, opcode, Rsrc, Rdest,
           imm, busy, halted, illegal
  );
endinterface

// File: rtl/inst_sequencer.sv
// Fetch/decode/execute controller: issues one 16-bit instruction from a
// synchronous ROM every three cycles and drives the datapath control bundle.
// The interface instance must be built with the same ADDR_W as this module.
module inst_sequencer #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input logic        clk,
  input logic        rst,
  inst_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_PAUSED, S_HALTED
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // The decoded-field flops are the instruction register: captured at the
  // DECODE->EXECUTE edge and held until the next instruction is decoded.
  logic [7:0]  opcode_q, opcode_d;
  logic [3:0]  rsrc_q, rsrc_d;
  logic [3:0]  rdest_q, rdest_d;
  logic [15:0] imm_q, imm_d;
  logic        rori_q, rori_d;
  logic        wr_q, wr_d;
  logic        flag_q, flag_d;
  logic        ill_q, ill_d;
  logic        halt_q, halt_d;

  logic [3:0]  hi, ext;
  logic [3:0]  dec_rsrc;
  logic [15:0] dec_imm;
  logic        dec_rori, dec_legal, dec_wr, dec_flag, dec_halt;

  // Combinational decode of the ROM word that is valid during DECODE.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    hi        = bus.imem_rdata[15:12];
    ext       = bus.imem_rdata[7:4];
    dec_rsrc  = bus.imem_rdata[3:0];
    dec_imm   = 16'h0000;
    dec_rori  = 1'b0;
    dec_legal = 1'b0;
    dec_wr    = 1'b0;
    dec_flag  = 1'b0;
    dec_halt  = 1'b0;
    case (hi)
      4'h0: begin
        if (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE}) begin
          dec_legal = 1'b1;
          dec_wr    = (ext != 4'hB);
          dec_flag  = ext inside {4'h5, 4'h7, 4'h9, 4'hA, 4'hB};
        end else if (bus.imem_rdata == 16'h0000) begin
          dec_legal = 1'b1;  // NOP: legal, no strobes
        end
      end
      4'h1, 4'h2, 4'h3, 4'hD: begin
        dec_legal = 1'b1;
        dec_wr    = 1'b1;
        dec_rori  = 1'b1;
        dec_rsrc  = 4'h0;
        dec_imm   = {8'h00, bus.imem_rdata[7:0]};
      end
      4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE: begin
        dec_legal = 1'b1;
        dec_wr    = (hi != 4'hB);
        dec_flag  = hi inside {4'h5, 4'h7, 4'h9, 4'hA, 4'hB};
        dec_rori  = 1'b1;
        dec_rsrc  = 4'h0;
        dec_imm   = {{8{bus.imem_rdata[7]}}, bus.imem_rdata[7:0]};
      end
      4'h8: begin
        if (ext == 4'h8 || ext == 4'hF) begin
          dec_legal = 1'b1;
          dec_wr    = 1'b1;
        end else if (ext[3:2] == 2'b00) begin
          dec_legal = 1'b1;
          dec_wr    = 1'b1;
          dec_rori  = 1'b1;
          dec_rsrc  = 4'h0;
          dec_imm   = {{11{bus.imem_rdata[4]}}, bus.imem_rdata[4:0]};
        end
      end
      4'hF: begin
        dec_legal = 1'b1;
        dec_halt  = 1'b1;
      end
      default: ;  // 4 and C are undefined: illegal, executed as NOP
    endcase
  end

  // State register, PC and instruction fields.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the asynchronous reset clears the state at once, so an instruction
    // in flight is aborted before any strobe can reach the datapath.
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= START_ADDR;
      opcode_q <= '0;
      rsrc_q   <= '0;
      rdest_q  <= '0;
      imm_q    <= '0;
      rori_q   <= 1'b0;
      wr_q     <= 1'b0;
      flag_q   <= 1'b0;
      ill_q    <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      rsrc_q   <= rsrc_d;
      rdest_q  <= rdest_d;
      imm_q    <= imm_d;
      rori_q   <= rori_d;
      wr_q     <= wr_d;
      flag_q   <= flag_d;
      ill_q    <= ill_d;
      halt_q   <= halt_d;
    end
  end

  // Next-state, PC advance and field capture.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    rsrc_d   = rsrc_q;
    rdest_d  = rdest_q;
    imm_d    = imm_q;
    rori_d   = rori_q;
    wr_d     = wr_q;
    flag_d   = flag_q;
    ill_d    = ill_q;
    halt_d   = halt_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = START_ADDR;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        state_d  = S_EXECUTE;
        opcode_d = {hi, ext};
        rsrc_d   = dec_rsrc;
        rdest_d  = bus.imem_rdata[11:8];
        imm_d    = dec_imm;
        rori_d   = dec_rori;
        wr_d     = dec_wr;
        flag_d   = dec_flag;
        ill_d    = ~dec_legal;
        halt_d   = dec_halt;
      end
      S_EXECUTE: begin
        pc_d = pc_q + 1'b1;  // wraps naturally at 2**ADDR_W
        if (halt_q)         state_d = S_HALTED;
        else if (bus.pause) state_d = S_PAUSED;
        else                state_d = S_FETCH;
      end
      S_PAUSED: if (!bus.pause) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: strobes only in EXECUTE, fields straight from the held flops.
  always_comb begin
    bus.imem_en   = (state_q == S_FETCH);
    bus.imem_addr = pc_q;
    bus.busy      = state_q inside {S_FETCH, S_DECODE, S_EXECUTE};
    bus.halted    = (state_q == S_HALTED);
    bus.regEnable = (state_q == S_EXECUTE && wr_q) ? (16'h0001 << rdest_q) : 16'h0000;
    bus.flagEn    = (state_q == S_EXECUTE) && flag_q;
    bus.illegal   = (state_q == S_EXECUTE) && ill_q;
    bus.opcode    = opcode_q;
    bus.Rsrc      = rsrc_q;
    bus.Rdest     = rdest_q;
    bus.imm       = imm_q;
    bus.RorI      = rori_q;
  end

endmodule
